fft_sp_framer: RTL and testbench

Parametrised successor to the fixed 4-lane serial-to-parallel stage at the front of the FFT datapath. It accepts one complex sample per handshake and assembles frames of POINTS samples into two ping-pong banks, reordering each frame to natural or bit-reversed order. It then delivers each frame as POINTS/LANES parallel beats to the mux/butterfly path. Valid/ready on both sides replaces the old free-running flag, so input and output can stall independently.

---
 rtl/fft_sp_framer_pkg.sv | 24 ++
 rtl/sp_bank.sv | 29 ++
 rtl/fft_sp_framer.sv | 90 +++++++++
 tb/tb_fft_sp_framer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_sp_framer_pkg.sv
// fft_pkg: shared sample types and index helpers for the FFT front end
package fft_pkg;
  localparam int DW = 17;
  localparam int SAMPLE_W = 2 * DW;

  typedef struct packed {
    logic [DW-1:0] im;
    logic [DW-1:0] re;
  } cplx_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic logic [31:0] bitrev(input logic [31:0] idx, input int nbits);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < nbits; i++) r[i] = idx[nbits-1-i];
    return r;
  endfunction
endpackage

// File: rtl/sp_bank.sv
// sp_bank: one frame of sample storage, single write port, LANES-wide beat read
module sp_bank import fft_pkg::*; #(
  parameter int SW = SAMPLE_W,
  parameter int POINTS = 16,
  parameter int LANES = 4,
  localparam int AW = clog2(POINTS),
  localparam int BW = (POINTS > LANES) ? clog2(POINTS / LANES) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic [AW-1:0]       addr,
  input  logic [SW-1:0]       wdata,
  input  logic [BW-1:0]       beat,
  output logic [LANES*SW-1:0] rdata
);
  logic [SW-1:0] mem [POINTS];

  // sample storage, cleared on reset so idle output data reads as zero
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int i = 0; i < POINTS; i++) mem[i] <= '0;
    else if (we)
      mem[addr] <= wdata;

  // unregistered beat read: lane k comes from address beat*LANES+k
  always_comb
    for (int k = 0; k < LANES; k++) rdata[k*SW +: SW] = mem[AW'(int'(beat) * LANES + k)];
endmodule

// File: rtl/fft_sp_framer.sv
// fft_sp_framer: ping-pong serial-to-parallel framer with optional bit-reversed order
module fft_sp_framer #(
  parameter int DW = 17,
  parameter int POINTS = 16,
  parameter int LANES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  bitrev_en,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2*DW-1:0]       in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES*2*DW-1:0] out_data,
  output logic                  out_sof,
  output logic                  out_eof,
  output logic                  frame_err
);
  import fft_pkg::*;

  localparam int SW = 2 * DW;
  localparam int AW = clog2(POINTS);
  localparam int NB = POINTS / LANES;
  localparam int BW = (NB > 1) ? clog2(NB) : 1;

  logic [AW-1:0]       wr_idx, addr;
  logic [BW-1:0]       beat;
  logic [1:0]          full;
  logic                wr_sel, rd_sel, mode, mode_eff, acc, wr_done, last_beat, drain;
  logic [LANES*SW-1:0] rd [2];

  assign in_ready  = !full[wr_sel];
  assign out_valid = full[rd_sel];
  assign acc       = in_valid && in_ready;
  assign wr_done   = acc && wr_idx == AW'(POINTS - 1);
  assign last_beat = beat == BW'(NB - 1);
  assign drain     = out_valid && out_ready && last_beat;
  assign mode_eff  = (wr_idx == '0) ? bitrev_en : mode;
  assign addr      = mode_eff ? AW'(bitrev(32'(wr_idx), AW)) : wr_idx;
  assign out_sof   = out_valid && beat == '0;
  assign out_eof   = out_valid && last_beat;
  assign out_data  = rd[rd_sel];

  // write side: index, bank select, per-frame order latch and short-frame error pulse
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_idx    <= '0;
      wr_sel    <= 1'b0;
      mode      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= acc && in_last && !wr_done;
      if (acc) begin
        if (wr_idx == '0) mode <= bitrev_en;
        wr_idx <= (wr_done || in_last) ? '0 : wr_idx + 1'b1;
        wr_sel <= wr_sel ^ wr_done;
      end
    end

  // read side: beat counter walks the frame, then hands the bank back
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      beat   <= '0;
      rd_sel <= 1'b0;
    end else if (out_valid && out_ready) begin
      beat   <= last_beat ? '0 : beat + 1'b1;
      rd_sel <= rd_sel ^ last_beat;
    end

  // bank occupancy: a completing frame's set overrides a same-cycle free
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      full <= '0;
    else
      full <= (full & ~({1'b0, drain} << rd_sel)) | ({1'b0, wr_done} << wr_sel);

  for (genvar b = 0; b < 2; b++) begin : g_bank
    sp_bank #(.SW(SW), .POINTS(POINTS), .LANES(LANES)) u_bank (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (acc && wr_sel == 1'(b)),
      .addr  (addr),
      .wdata (in_data),
      .beat  (beat),
      .rdata (rd[b])
    );
  end
endmodule

// File: tb/tb_fft_sp_framer.sv
// tb_fft_sp_framer: table-driven and directed checks against a frame-queue model
module tb_fft_sp_framer;
  localparam int DW = 17, POINTS = 16, LANES = 4, SW = 2 * DW, NB = POINTS / LANES, W = LANES * SW;

  logic clk = 1'b0, rst_n = 1'b0, bitrev_en = 1'b0, in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [SW-1:0] in_data = '0;
  logic in_ready, out_valid, out_sof, out_eof, frame_err;
  logic [W-1:0] out_data;

  always #5 clk = ~clk;

  fft_sp_framer #(.DW(DW), .POINTS(POINTS), .LANES(LANES)) dut (
    .clk(clk), .rst_n(rst_n), .bitrev_en(bitrev_en), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sof(out_sof), .out_eof(out_eof), .frame_err(frame_err)
  );

  typedef logic [SW-1:0] frame_t [POINTS];
  typedef struct {
    bit br; int n; int last_at; bit tog;
    int exp_beats; int exp_errs; int idx; logic [W-1:0] beat;
  } vec_t;

  frame_t fq[$];
  logic [SW-1:0] part [POINTS];
  logic [W-1:0] seen[$];
  logic [W-1:0] held;
  vec_t v [5];
  int nfull, beat_m, widx, checks, errors, beats_seen, errs_seen, stalls;
  bit mode_m, err_m;

  function automatic logic [SW-1:0] smp(input int i);
    return {17'(100 + i), 17'(i)};
  endfunction

  function automatic int rev4(input int i);
    return ((i & 1) << 3) | ((i & 2) << 1) | ((i & 4) >> 1) | ((i & 8) >> 3);
  endfunction

  function automatic logic [W-1:0] mk_beat(input int a, input int b, input int c, input int d);
    return {smp(d), smp(c), smp(b), smp(a)};
  endfunction

  function automatic logic [W-1:0] exp_data();
    logic [W-1:0] r;
    for (int k = 0; k < LANES; k++) r[k*SW +: SW] = fq[0][beat_m*LANES+k];
    return r;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    fq.delete();
    nfull = 0; beat_m = 0; widx = 0; mode_m = 0; err_m = 0;
  endtask

  // compare at negedge, then advance the model across the next posedge
  task automatic step();
    bit acc, drn;
    frame_t f;
    chk("in_ready", W'(in_ready), W'(nfull < 2));
    chk("out_valid", W'(out_valid), W'(nfull > 0));
    chk("frame_err", W'(frame_err), W'(err_m));
    chk("out_sof", W'(out_sof), W'(nfull > 0 && beat_m == 0));
    chk("out_eof", W'(out_eof), W'(nfull > 0 && beat_m == NB - 1));
    if (nfull > 0) chk("out_data", out_data, exp_data());
    if (frame_err) errs_seen++;
    if (in_valid && !in_ready) stalls++;
    if (out_valid && out_ready) begin
      beats_seen++;
      seen.push_back(out_data);
    end
    acc = in_valid && nfull < 2;
    drn = out_ready && nfull > 0;
    @(posedge clk);
    err_m = 0;
    if (drn) begin
      if (beat_m == NB - 1) begin
        beat_m = 0;
        fq.delete(0);
        nfull--;
      end else beat_m++;
    end
    if (acc) begin
      if (widx == 0) mode_m = bitrev_en;
      part[widx] = in_data;
      if (widx == POINTS - 1) begin
        for (int i = 0; i < POINTS; i++) f[mode_m ? rev4(i) : i] = part[i];
        fq.push_back(f);
        nfull++;
        widx = 0;
      end else if (in_last) begin
        widx = 0;
        err_m = 1;
      end else widx++;
    end
    @(negedge clk);
  endtask

  task automatic send(input bit br, input int n, input int last_at, input bit tog);
    int i = 0, g = 0;
    while (i < n && g < 2000) begin
      in_valid = 1'b1;
      in_data = smp(i);
      in_last = (i == last_at);
      bitrev_en = (tog && i % 2 == 1) ? !br : br;
      if (in_ready) i++;
      step();
      g++;
    end
    chk("send_count", W'(i), W'(n));
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while ((nfull > 0 || err_m || frame_err) && g < 200) begin
      step();
      g++;
    end
    chk("drain_done", W'(nfull), W'(0));
    step();
  endtask

  task automatic clear_stats();
    beats_seen = 0; errs_seen = 0; stalls = 0;
    seen.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, W'(in_ready), W'(1));
    chk({tag, "_out_valid"}, W'(out_valid), W'(0));
    chk({tag, "_out_sof"}, W'(out_sof), W'(0));
    chk({tag, "_out_eof"}, W'(out_eof), W'(0));
    chk({tag, "_frame_err"}, W'(frame_err), W'(0));
    chk({tag, "_out_data"}, out_data, W'(0));
  endtask

  task automatic areset(input string tag);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs(tag);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    checks = 0; errors = 0;
    model_reset();
    clear_stats();
    v[0] = '{0, 16, -1, 0, 4, 0, 3, mk_beat(12, 13, 14, 15)};
    v[1] = '{1, 16, -1, 0, 4, 0, 1, mk_beat(2, 10, 6, 14)};
    v[2] = '{1, 16, -1, 1, 4, 0, 3, mk_beat(3, 11, 7, 15)};
    v[3] = '{0, 22, 5, 0, 4, 1, 0, mk_beat(6, 7, 8, 9)};
    v[4] = '{0, 160, -1, 0, 40, 0, 39, mk_beat(156, 157, 158, 159)};

    #1 check_reset_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;

    out_ready = 1'b1;
    for (int t = 0; t < 5; t++) begin
      clear_stats();
      send(v[t].br, v[t].n, v[t].last_at, v[t].tog);
      drain();
      chk($sformatf("v%0d_beats", t), W'(beats_seen), W'(v[t].exp_beats));
      chk($sformatf("v%0d_errs", t), W'(errs_seen), W'(v[t].exp_errs));
      chk($sformatf("v%0d_stalls", t), W'(stalls), W'(0));
      if (seen.size() > v[t].idx) chk($sformatf("v%0d_beat", t), seen[v[t].idx], v[t].beat);
      else chk($sformatf("v%0d_beat_missing", t), W'(seen.size()), W'(v[t].idx + 1));
    end

    clear_stats();
    out_ready = 1'b0;
    begin
      int acc_cnt = 0;
      for (int c = 0; c < 45; c++) begin
        in_valid = 1'b1;
        in_data = smp(acc_cnt);
        bitrev_en = 1'b0;
        if (c == 33) held = out_data;
        if (in_ready) acc_cnt++;
        step();
      end
      chk("bp_accepts", W'(acc_cnt), W'(32));
    end
    chk("bp_ready_low", W'(in_ready), W'(0));
    chk("bp_hold", out_data, held);
    in_valid = 1'b0;
    out_ready = 1'b1;
    begin
      int g = 0;
      while (!out_eof && g < 20) begin
        step();
        g++;
      end
      chk("bp_eof_seen", W'(out_eof), W'(1));
      step();
      chk("bp_ready_rise", W'(in_ready), W'(1));
    end
    drain();
    chk("bp_beats", W'(beats_seen), W'(8));
    if (seen.size() >= 8) begin
      chk("bp_frame_a", seen[0], mk_beat(0, 1, 2, 3));
      chk("bp_frame_b", seen[4], mk_beat(16, 17, 18, 19));
    end else chk("bp_seen", W'(seen.size()), W'(8));

    send(0, 7, -1, 0);
    areset("rst_mid_in");
    clear_stats();
    send(0, 16, -1, 0);
    drain();
    chk("rst1_beats", W'(beats_seen), W'(4));
    if (seen.size() > 0) chk("rst1_beat0", seen[0], mk_beat(0, 1, 2, 3));

    send(1, 16, -1, 0);
    begin
      int g = 0;
      while (beat_m < 2 && g < 20) begin
        step();
        g++;
      end
      chk("rst2_beat", W'(beat_m), W'(2));
    end
    areset("rst_mid_out");
    clear_stats();
    send(0, 16, -1, 0);
    drain();
    chk("rst2_beats", W'(beats_seen), W'(4));
    if (seen.size() > 0) chk("rst2_beat0", seen[0], mk_beat(0, 1, 2, 3));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
